// File: rtl/h14rx_chan_dec_if.sv
// Bundle between the deserializer, one h14rx channel decoder and the
// receiver timing recovery logic.
//
// Stream semantics: there is no back-pressure and no ready signal. The
// decoder takes one symbol every pixel_clk cycle and presents one decoded
// symbol every cycle. Exactly one of de / ctrl_valid / aux_valid qualifies
// the current output word. Consumers additionally qualify with locked.
interface h14rx_chan_dec_if;
    logic [9:0] tmds_sym;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [7:0] data;
    logic [1:0] c;
    logic       ctrl_valid;
    logic [3:0] aux;
    logic       aux_valid;
    logic [1:0] dbg_state;

    // Decoder side.
    modport master (
        input  tmds_sym,
        output bitslip, locked, de, data, c, ctrl_valid, aux, aux_valid,
        output dbg_state
    );

    // Deserializer / downstream side.
    modport slave (
        output tmds_sym,
        input  bitslip, locked, de, data, c, ctrl_valid, aux, aux_valid,
        input  dbg_state
    );
endinterface

// File: rtl/h14rx_chan_dec.sv
// h14rx_chan_dec: receive-side TMDS channel decoder and word aligner.
//
// Registers the deserialized symbol, classifies it (control / TERC4 / data),
// decodes it and registers the result (2-cycle latency). A run detector on
// the registered symbol drives the SEARCH/SLIP/SETTLE/LOCKED alignment FSM,
// which pulses bitslip until a blanking run of MinRun identical control
// tokens is seen inside the search window.
//
// Optional feature: define H14RX_TERC4_EN to decode the 16 TERC4 codes onto
// aux/aux_valid. Without it aux/aux_valid are constant 0 and TERC4 codes are
// decoded as video data.
module h14rx_chan_dec #(
    parameter int MinRun       = 8,
    parameter int SearchCycles = 65536,
    parameter int SlipWait     = 16
) (
    input  logic                pixel_clk,
    input  logic                rst_n,
    h14rx_chan_dec_if.master    bus
);

    localparam int WinW = (SearchCycles > 1) ? $clog2(SearchCycles) : 1;
    localparam int SetW = (SlipWait > 0) ? $clog2(SlipWait + 1) : 1;
    localparam int RunW = $clog2(MinRun + 1);

    localparam logic [WinW-1:0] WinLast = WinW'(SearchCycles - 1);
    localparam logic [SetW-1:0] SetLast = SetW'(SlipWait - 1);
    localparam logic [RunW-1:0] RunMax  = RunW'(MinRun);
    localparam logic [RunW-1:0] RunOne  = RunW'(1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Input and history registers
    logic [9:0]      sym_q;
    logic [9:0]      prev_q;

    // Classification of the registered symbol
    logic            is_ctrl;
    logic [1:0]      ctrl_bits;
    logic            is_terc;
    logic [3:0]      terc_bits;
    logic [7:0]      d_w;
    logic [7:0]      data_dec;

    // Registered outputs
    logic            de_q,         de_d;
    logic [7:0]      data_q,       data_d;
    logic [1:0]      c_q,          c_d;
    logic            ctrl_valid_q, ctrl_valid_d;
    logic [3:0]      aux_q,        aux_d;
    logic            aux_valid_q,  aux_valid_d;
    logic            bitslip_q,    bitslip_d;

    // Run detector and alignment FSM
    logic [RunW-1:0] run_q,        run_d;
    logic            run_hit;
    state_t          state_q,      state_d;
    logic [WinW-1:0] win_q,        win_d;
    logic [SetW-1:0] settle_q,     settle_d;

    // Recognise the four control tokens.
    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_bits = 2'b00;
        case (sym_q)
            10'b1101010100: ctrl_bits = 2'b00;
            10'b0010101011: ctrl_bits = 2'b01;
            10'b0101010100: ctrl_bits = 2'b10;
            10'b1010101011: ctrl_bits = 2'b11;
            default:        is_ctrl   = 1'b0;
        endcase
    end

`ifdef H14RX_TERC4_EN
    // Recognise the sixteen TERC4 codes.
    always_comb begin
        is_terc   = 1'b1;
        terc_bits = 4'h0;
        case (sym_q)
            10'b1010011100: terc_bits = 4'h0;
            10'b1001100011: terc_bits = 4'h1;
            10'b1011100100: terc_bits = 4'h2;
            10'b1011100010: terc_bits = 4'h3;
            10'b0101110001: terc_bits = 4'h4;
            10'b0100011110: terc_bits = 4'h5;
            10'b0110001110: terc_bits = 4'h6;
            10'b0100111100: terc_bits = 4'h7;
            10'b1011001100: terc_bits = 4'h8;
            10'b0100111001: terc_bits = 4'h9;
            10'b0110011100: terc_bits = 4'hA;
            10'b1011000110: terc_bits = 4'hB;
            10'b1010001110: terc_bits = 4'hC;
            10'b1001110001: terc_bits = 4'hD;
            10'b0101100011: terc_bits = 4'hE;
            10'b1011000011: terc_bits = 4'hF;
            default:        is_terc   = 1'b0;
        endcase
    end
`else
    assign is_terc   = 1'b0;
    assign terc_bits = 4'h0;
`endif

    // Undo the DC-balance inversion (bit 9), then the XOR/XNOR chain (bit 8).
    assign d_w      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    assign data_dec = {d_w[7:1] ^ d_w[6:0] ^ {7{~sym_q[8]}}, d_w[0]};

    // Select one symbol class per cycle; fields of other classes read as 0.
    always_comb begin
        de_d         = 1'b0;
        data_d       = 8'h00;
        c_d          = 2'b00;
        ctrl_valid_d = 1'b0;
        aux_d        = 4'h0;
        aux_valid_d  = 1'b0;
        if (is_ctrl) begin
            ctrl_valid_d = 1'b1;
            c_d          = ctrl_bits;
        end else if (is_terc) begin
            aux_valid_d  = 1'b1;
            aux_d        = terc_bits;
        end else begin
            de_d         = 1'b1;
            data_d       = data_dec;
        end
    end

    // Capture the incoming symbol and the decoded output word.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_q        <= 10'h000;
            prev_q       <= 10'h000;
            de_q         <= 1'b0;
            data_q       <= 8'h00;
            c_q          <= 2'b00;
            ctrl_valid_q <= 1'b0;
            aux_q        <= 4'h0;
            aux_valid_q  <= 1'b0;
        end else begin
            sym_q        <= bus.tmds_sym;
            prev_q       <= sym_q;
            de_q         <= de_d;
            data_q       <= data_d;
            c_q          <= c_d;
            ctrl_valid_q <= ctrl_valid_d;
            aux_q        <= aux_d;
            aux_valid_q  <= aux_valid_d;
        end
    end

    // Count identical consecutive control tokens; frozen at 0 while settling.
    always_comb begin
        run_d = '0;
        if (state_q != ST_SETTLE && is_ctrl) begin
            if (sym_q == prev_q) begin
                run_d = (run_q == RunMax) ? run_q : run_q + RunOne;
            end else begin
                run_d = RunOne;
            end
        end
    end

    // A hit is the single cycle where the count first reaches MinRun.
    assign run_hit = (run_d == RunMax) && (run_q != RunMax);

    // Run counter register.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Alignment FSM next state; a run hit always beats window expiry.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        settle_d = settle_q;
        case (state_q)
            ST_SEARCH, ST_LOCKED: begin
                win_d = win_q + 1'b1;
                if (run_hit) begin
                    state_d = ST_LOCKED;
                    win_d   = '0;
                end else if (win_q == WinLast) begin
                    state_d = ST_SLIP;
                    win_d   = '0;
                end
            end
            ST_SLIP: begin
                state_d  = ST_SETTLE;
                win_d    = '0;
                settle_d = '0;
            end
            ST_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SetLast) begin
                    state_d  = ST_SEARCH;
                    win_d    = '0;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                win_d    = '0;
                settle_d = '0;
            end
        endcase
        bitslip_d = (state_d == ST_SLIP);
    end

    // Alignment FSM registers; bitslip is high exactly while in SLIP.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            win_q     <= '0;
            settle_q  <= '0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            settle_q  <= settle_d;
            bitslip_q <= bitslip_d;
        end
    end

    assign bus.bitslip    = bitslip_q;
    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.de         = de_q;
    assign bus.data       = data_q;
    assign bus.c          = c_q;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.aux        = aux_q;
    assign bus.aux_valid  = aux_valid_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_h14rx_chan_dec.sv
// Bench for h14rx_chan_dec with a short search window so alignment
// sequences stay small. Decoded outputs are checked by a scoreboard fed at
// drive time; alignment behaviour is checked against cycle numbers derived
// from the alignment rules.
module tb_h14rx_chan_dec;

  localparam int MIN_RUN = 8;
  localparam int SC      = 64;
  localparam int SW      = 16;
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TERC_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // ---------------- clock / reset ----------------
  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b0;
  int   cyc       = 0;

  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  h14rx_chan_dec_if bus();

  h14rx_chan_dec #(
    .MinRun(MIN_RUN),
    .SearchCycles(SC),
    .SlipWait(SW)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];   // {ctrl_valid, c, de, data, aux_valid, aux}
  int          due_q[$];
  int          slip_cyc[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          last_k  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_ctrl(input logic [9:0] s);
    return s inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  endfunction

  function automatic logic [16:0] model(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] dat;
    case (s)
      10'b1101010100: return {1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'h0};
      10'b0010101011: return {1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 4'h0};
      10'b0101010100: return {1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 4'h0};
      10'b1010101011: return {1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 4'h0};
      default: ;
    endcase
`ifdef H14RX_TERC4_EN
    for (int i = 0; i < 16; i++) begin
      if (TERC_TAB[i] == s) return {1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 4'(i)};
    end
`endif
    d = s[9] ? ~s[7:0] : s[7:0];
    dat[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dat[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return {1'b0, 2'd0, 1'b1, dat, 1'b0, 4'h0};
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] x, input int n);
    logic [19:0] w;
    w = {x, x};
    return w[n +: 10];
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    do s = 10'($urandom_range(0, 1023)); while (is_ctrl(s));
    return s;
  endfunction

  // ---------------- driver ----------------
  // Drive one symbol after the falling edge, then return just after the
  // next rising edge so callers can sample outputs for that cycle.
  task automatic step(input logic [9:0] s);
    @(negedge pixel_clk);
    bus.tmds_sym = s;
    last_k = cyc;
    exp_q.push_back(model(s));
    due_q.push_back(cyc + 2);
    @(posedge pixel_clk);
    #1;
    if (bus.bitslip) slip_cyc.push_back(cyc);
  endtask

  task automatic apply_reset();
    @(posedge pixel_clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    repeat (2) @(negedge pixel_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [16:0] mon_e, mon_act, mon_mask;
  int          mon_due;
  logic        aux_chk;

  always @(posedge pixel_clk) begin
    #1;
    if (rst_n) begin
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        mon_e   = exp_q.pop_front();
        mon_due = due_q.pop_front();
`ifdef H14RX_TERC4_EN
        aux_chk = mon_e[4];
`else
        aux_chk = 1'b1;
`endif
        mon_act  = {bus.ctrl_valid, bus.c, bus.de, bus.data, bus.aux_valid, bus.aux};
        mon_mask = {1'b1, {2{mon_e[16]}}, 1'b1, {8{mon_e[13]}}, 1'b1, {4{aux_chk}}};
        check($sformatf("decode_due%0d", mon_due), 32'(mon_act & mon_mask), 32'(mon_e & mon_mask));
      end
    end
  end

  // ---------------- stimulus ----------------
  int h, e, h2, e2;
  int off;
  bit seen;

  initial begin
    bus.tmds_sym = 10'h000;
    rst_n = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_bitslip",    32'(bus.bitslip),    0);
    check("rst_locked",     32'(bus.locked),     0);
    check("rst_de",         32'(bus.de),         0);
    check("rst_ctrl_valid", 32'(bus.ctrl_valid), 0);
    check("rst_aux_valid",  32'(bus.aux_valid),  0);
    check("rst_data",       32'(bus.data),       0);
    check("rst_c",          32'(bus.c),          0);
    check("rst_aux",        32'(bus.aux),        0);
    @(negedge pixel_clk);
    rst_n = 1'b1;

    // Run of 20 identical tokens: lock two cycles after the 8th.
    h = 0;
    for (int i = 1; i <= 20; i++) begin
      step(TOK0);
      if (i == MIN_RUN) h = last_k + 2;
      check($sformatf("lock_run_t%0d", i), 32'(bus.locked), 32'(i >= MIN_RUN + 1));
      check("lock_run_no_slip", 32'(bus.bitslip), 0);
    end

    // Directed and random decode while locked.
    step(10'b0100000000);
    step(10'b1011111111);
    step(10'b0011111111);
    for (int i = 0; i < 16; i++) step(TERC_TAB[i]);
    for (int i = 0; i < 8; i++) step(10'($urandom_range(0, 1023)) & 10'h3FF);

    // Data-only traffic: locked falls with a bitslip on window expiry.
    while (cyc < h + SC + 2) begin
      step(rand_data());
      check("expiry_locked", 32'(bus.locked), 32'(cyc < h + SC));
      check("expiry_bitslip", 32'(bus.bitslip), 32'(cyc == h + SC));
    end
    e = h + SC;

    // Relock: counting starts at the first SEARCH cycle after settling.
    h2 = -1;
    for (int i = 0; i < 80 && h2 < 0; i++) begin
      step(TOK0);
      if (bus.locked) h2 = cyc;
    end
    check("relock_seen", 32'(h2 >= 0), 1);
    check("relock_cycle", 32'(h2), 32'(e + SW + 9));

    // A run completing on the expiry cycle keeps the lock.
    e2 = h2 + SC;
    while (cyc < e2 + 3) begin
      step((cyc >= e2 - 9 && cyc <= e2 - 2) ? TOK0 : rand_data());
      check("race_locked", 32'(bus.locked), 1);
      check("race_no_slip", 32'(bus.bitslip), 0);
    end

    // Word rotated by 3: three slips, evenly spaced, then lock on c=00.
    apply_reset();
    slip_cyc.delete();
    off = 3;
    for (int i = 0; i < 700 && !bus.locked; i++) begin
      step(rot(TOK0, off));
      if (bus.bitslip) off = (off + 9) % 10;
    end
    check("rot_slip_count", 32'(slip_cyc.size()), 3);
    if (slip_cyc.size() >= 3) begin
      check("rot_slip_gap1", 32'(slip_cyc[1] - slip_cyc[0]), 32'(SC + SW + 1));
      check("rot_slip_gap2", 32'(slip_cyc[2] - slip_cyc[1]), 32'(SC + SW + 1));
    end
    check("rot_locked",     32'(bus.locked),     1);
    check("rot_c",          32'(bus.c),          0);
    check("rot_ctrl_valid", 32'(bus.ctrl_valid), 1);
    for (int i = 0; i < 4; i++) step(TOK0);

    // Reset asserted in the middle of SETTLE.
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(rand_data());
      seen = bus.bitslip;
    end
    check("settle_slip_seen", 32'(seen), 1);
    repeat (5) step(rand_data());
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    check("mid_rst_bitslip",    32'(bus.bitslip),    0);
    check("mid_rst_locked",     32'(bus.locked),     0);
    check("mid_rst_de",         32'(bus.de),         0);
    check("mid_rst_ctrl_valid", 32'(bus.ctrl_valid), 0);
    check("mid_rst_aux_valid",  32'(bus.aux_valid),  0);
    check("mid_rst_data",       32'(bus.data),       0);
    check("mid_rst_c",          32'(bus.c),          0);
    check("mid_rst_aux",        32'(bus.aux),        0);
    repeat (2) @(negedge pixel_clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(TOK0);
      check($sformatf("relock_rst_t%0d", i), 32'(bus.locked), 32'(i >= MIN_RUN + 1));
    end

    // Drain the scoreboard.
    for (int i = 0; i < 6; i++) step(rand_data());
    repeat (3) @(posedge pixel_clk);
    #2;
    check("queue_empty", 32'(due_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
